// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory arbiter.
//   Owner tags name the requester a read response belongs to; OWN_NONE
//   marks an empty pipeline slot (idle cycle or write).
//   arb_state_t is the lock FSM state: normal arbitration or debug-exclusive.
package mem_arb_pkg;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_I    = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;
    localparam logic [1:0] OWN_G    = 2'd3;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_LOCK   = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// Owner-tag delay line matching the memory read latency.
//   clk, reset : clock, asynchronous active-high reset (clears all stages)
//   tag_in     : owner tag of the command issued this cycle (OWN_NONE if none/write)
//   tag_out    : tag whose read data is on m_rdata this cycle
//   empty      : no read is in flight in any stage
module mem_arb_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] tag_in,
    output logic [1:0] tag_out,
    output logic       empty
);

    logic [1:0] stage [MEM_LAT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                stage[i] <= OWN_NONE;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < MEM_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[MEM_LAT-1];

    always_comb begin
        empty = 1'b1;
        for (int i = 0; i < MEM_LAT; i++) begin
            if (stage[i] != OWN_NONE) empty = 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Three-way arbiter in front of a single-port unified memory.
//   Requesters: I (instruction fetch, read only), D (load/store), G (debug/loader).
//   Each requester: *_req / *_addr (+ *_we / *_wdata for D, G) in; *_gnt
//   (same-cycle accept), *_rvalid / *_rdata (read response) out.
//   g_lock / g_locked : debug exclusive-access request / active.
//   m_en, m_addr, m_we, m_wdata : memory command; m_rdata returns MEM_LAT
//   cycles after a read (MEM_LAT legal range 1..4).
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_NORMAL | G > D > I, fetch forced through after STARVE_MAX denials;
//             | while g_lock is high I/D are held off until reads drain
//   ST_LOCK   | only G is granted; leaves the cycle after g_lock is seen low
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [DW-1:0]   i_rdata,

    input  logic            d_req,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW/8-1:0] d_we,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,

    input  logic            g_req,
    input  logic            g_lock,
    input  logic [AW-1:0]   g_addr,
    input  logic [DW/8-1:0] g_we,
    input  logic [DW-1:0]   g_wdata,
    output logic            g_gnt,
    output logic            g_rvalid,
    output logic [DW-1:0]   g_rdata,
    output logic            g_locked,

    output logic            m_en,
    output logic [AW-1:0]   m_addr,
    output logic [DW/8-1:0] m_we,
    output logic [DW-1:0]   m_wdata,
    input  logic [DW-1:0]   m_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    arb_state_t    state;
    logic [SW-1:0] starve_cnt;
    logic [1:0]    grant_own;
    logic [1:0]    tag_in;
    logic [1:0]    out_tag;
    logic          pipe_empty;
    logic          id_blocked;
    logic          i_ok;
    logic          d_ok;
    logic          starved;
    logic [DW-1:0] i_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic [DW-1:0] g_rdata_q;
    logic          unused_addr_lsbs;

    // Memory is word addressed; byte lanes come from the write enables.
    assign unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0], g_addr[1:0]};

    // I/D are held off for the whole lock request, not only while draining,
    // so no new read can slip into the pipeline just before entering LOCK.
    always_comb begin
        id_blocked = (state == ST_LOCK) || g_lock;
        i_ok       = i_req && !id_blocked;
        d_ok       = d_req && !id_blocked;
        starved    = i_ok && (starve_cnt == SW'(STARVE_MAX));
        grant_own  = OWN_NONE;
        if (reset)       grant_own = OWN_NONE;
        else if (starved) grant_own = OWN_I;
        else if (g_req)  grant_own = OWN_G;
        else if (d_ok)   grant_own = OWN_D;
        else if (i_ok)   grant_own = OWN_I;
    end

    assign i_gnt = (grant_own == OWN_I);
    assign d_gnt = (grant_own == OWN_D);
    assign g_gnt = (grant_own == OWN_G);
    assign m_en  = i_gnt | d_gnt | g_gnt;

    always_comb begin
        m_addr  = '0;
        m_we    = '0;
        m_wdata = '0;
        tag_in  = OWN_NONE;
        case (grant_own)
            OWN_I: begin
                m_addr = {i_addr[AW-1:2], 2'b00};
                tag_in = OWN_I;
            end
            OWN_D: begin
                m_addr  = {d_addr[AW-1:2], 2'b00};
                m_we    = d_we;
                m_wdata = d_wdata;
                if (d_we == '0) tag_in = OWN_D;
            end
            OWN_G: begin
                m_addr  = {g_addr[AW-1:2], 2'b00};
                m_we    = g_we;
                m_wdata = g_wdata;
                if (g_we == '0) tag_in = OWN_G;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_NORMAL;
            g_locked   <= 1'b0;
            starve_cnt <= '0;
        end else begin
            if (i_req && !i_gnt) begin
                if (starve_cnt != SW'(STARVE_MAX)) starve_cnt <= starve_cnt + SW'(1);
            end else begin
                starve_cnt <= '0;
            end
            case (state)
                ST_NORMAL: begin
                    if (g_lock && pipe_empty) begin
                        state    <= ST_LOCK;
                        g_locked <= 1'b1;
                    end
                end
                ST_LOCK: begin
                    if (!g_lock) begin
                        state      <= ST_NORMAL;
                        g_locked   <= 1'b0;
                        starve_cnt <= '0;
                    end
                end
                default: state <= ST_NORMAL;
            endcase
        end
    end

    mem_arb_tag_pipe #(.MEM_LAT(MEM_LAT)) u_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (tag_in),
        .tag_out (out_tag),
        .empty   (pipe_empty)
    );

    assign i_rvalid = (out_tag == OWN_I);
    assign d_rvalid = (out_tag == OWN_D);
    assign g_rvalid = (out_tag == OWN_G);

    // Pass-through on the response cycle, otherwise hold the last value.
    assign i_rdata = i_rvalid ? m_rdata : i_rdata_q;
    assign d_rdata = d_rvalid ? m_rdata : d_rdata_q;
    assign g_rdata = g_rvalid ? m_rdata : g_rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            g_rdata_q <= '0;
        end else begin
            if (i_rvalid) i_rdata_q <= m_rdata;
            if (d_rvalid) d_rdata_q <= m_rdata;
            if (g_rvalid) g_rdata_q <= m_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int SMAX = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          i_req, d_req, g_req, g_lock;
    logic [AW-1:0] i_addr, d_addr, g_addr;
    logic [BW-1:0] d_we, g_we;
    logic [DW-1:0] d_wdata, g_wdata;

    // index 0: MEM_LAT = 1 instance, index 1: MEM_LAT = 3 instance
    logic [1:0]    i_gnt, i_rvalid, d_gnt, d_rvalid, g_gnt, g_rvalid, g_locked, m_en;
    logic [DW-1:0] i_rdata [2];
    logic [DW-1:0] d_rdata [2];
    logic [DW-1:0] g_rdata [2];
    logic [DW-1:0] m_wdata [2];
    logic [DW-1:0] m_rdata [2];
    logic [AW-1:0] m_addr  [2];
    logic [BW-1:0] m_we    [2];

    mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1), .STARVE_MAX(SMAX)) u_lat1 (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt[0]), .i_rvalid(i_rvalid[0]), .i_rdata(i_rdata[0]),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
        .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
        .g_req(g_req), .g_lock(g_lock), .g_addr(g_addr), .g_we(g_we), .g_wdata(g_wdata),
        .g_gnt(g_gnt[0]), .g_rvalid(g_rvalid[0]), .g_rdata(g_rdata[0]), .g_locked(g_locked[0]),
        .m_en(m_en[0]), .m_addr(m_addr[0]), .m_we(m_we[0]), .m_wdata(m_wdata[0]), .m_rdata(m_rdata[0])
    );

    mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(3), .STARVE_MAX(SMAX)) u_lat3 (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt[1]), .i_rvalid(i_rvalid[1]), .i_rdata(i_rdata[1]),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
        .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
        .g_req(g_req), .g_lock(g_lock), .g_addr(g_addr), .g_we(g_we), .g_wdata(g_wdata),
        .g_gnt(g_gnt[1]), .g_rvalid(g_rvalid[1]), .g_rdata(g_rdata[1]), .g_locked(g_locked[1]),
        .m_en(m_en[1]), .m_addr(m_addr[1]), .m_we(m_we[1]), .m_wdata(m_wdata[1]), .m_rdata(m_rdata[1])
    );

    // Memory macro: 256 words, one shared array, one read-data pipe per instance.
    logic [DW-1:0] mem [256];
    logic [DW-1:0] rd_pipe [2][4];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            for (int s = 3; s > 0; s--) rd_pipe[k][s] <= rd_pipe[k][s-1];
            rd_pipe[k][0] <= (m_en[k] && m_we[k] == '0) ? mem[m_addr[k][9:2]] : 32'hDEAD_BEEF;
        end
        if (m_en[0] && m_we[0] != '0) begin
            for (int b = 0; b < BW; b++) begin
                if (m_we[0][b]) mem[m_addr[0][9:2]][8*b +: 8] <= m_wdata[0][8*b +: 8];
            end
        end
    end

    assign m_rdata[0] = rd_pipe[0][0];
    assign m_rdata[1] = rd_pipe[1][2];

    // Reference model: per-instance lock flag, starvation count, and the
    // expected responses keyed by the cycle they are due.
    int unsigned   cyc;
    int            n_checks = 0;
    int            n_errors = 0;
    int            starve [2];
    bit            locked [2];
    int            n_fly  [2];
    logic [1:0]    ring_own [2][8];
    logic [DW-1:0] ring_dat [2][8];
    logic [DW-1:0] held [2][4];
    logic [1:0]    last_win;
    logic          obs_i_gnt, obs_d_gnt, obs_d_rvalid, obs_g_locked;
    logic [AW-1:0] obs_m_addr;
    logic [BW-1:0] obs_m_we;

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", nm, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            starve[k] = 0;
            locked[k] = 1'b0;
            n_fly[k]  = 0;
            for (int s = 0; s < 8; s++) ring_own[k][s] = OWN_NONE;
            for (int o = 0; o < 4; o++) held[k][o] = '0;
        end
    endtask

    task automatic do_reset();
        string s;
        reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            s = (k == 0) ? "lat1" : "lat3";
            chk({"rst i_gnt ", s},    32'(i_gnt[k]),    32'd0);
            chk({"rst d_gnt ", s},    32'(d_gnt[k]),    32'd0);
            chk({"rst g_gnt ", s},    32'(g_gnt[k]),    32'd0);
            chk({"rst i_rvalid ", s}, 32'(i_rvalid[k]), 32'd0);
            chk({"rst d_rvalid ", s}, 32'(d_rvalid[k]), 32'd0);
            chk({"rst g_rvalid ", s}, 32'(g_rvalid[k]), 32'd0);
            chk({"rst m_en ", s},     32'(m_en[k]),     32'd0);
            chk({"rst m_we ", s},     32'(m_we[k]),     32'd0);
            chk({"rst g_locked ", s}, 32'(g_locked[k]), 32'd0);
        end
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One clock cycle: inputs were driven at the preceding negedge.
    task automatic step();
        bit            ok [4];
        logic [1:0]    order [3];
        logic [1:0]    win, own;
        logic [AW-1:0] a;
        logic [BW-1:0] we;
        logic [DW-1:0] wd;
        logic [2:0]    slot;
        bit            infl;
        string         s;
        #1;
        slot         = 3'(cyc);
        obs_i_gnt    = i_gnt[0];
        obs_d_gnt    = d_gnt[0];
        obs_d_rvalid = d_rvalid[0];
        obs_g_locked = g_locked[0];
        obs_m_addr   = m_addr[0];
        obs_m_we     = m_we[0];
        for (int k = 0; k < 2; k++) begin
            s = (k == 0) ? "lat1" : "lat3";
            ok[OWN_NONE] = 1'b0;
            ok[OWN_I]    = i_req && !(locked[k] || g_lock);
            ok[OWN_D]    = d_req && !(locked[k] || g_lock);
            ok[OWN_G]    = g_req;
            if (ok[OWN_I] && starve[k] == SMAX) order = '{OWN_I, OWN_G, OWN_D};
            else                                order = '{OWN_G, OWN_D, OWN_I};
            win = OWN_NONE;
            for (int j = 0; j < 3; j++) if (win == OWN_NONE && ok[order[j]]) win = order[j];
            a = '0; we = '0; wd = '0;
            case (win)
                OWN_I: a = i_addr;
                OWN_D: begin a = d_addr; we = d_we; wd = d_wdata; end
                OWN_G: begin a = g_addr; we = g_we; wd = g_wdata; end
                default: ;
            endcase
            chk({"i_gnt ", s}, 32'(i_gnt[k]), 32'(win == OWN_I));
            chk({"d_gnt ", s}, 32'(d_gnt[k]), 32'(win == OWN_D));
            chk({"g_gnt ", s}, 32'(g_gnt[k]), 32'(win == OWN_G));
            chk({"m_en ", s},  32'(m_en[k]),  32'(win != OWN_NONE));
            if (win != OWN_NONE) begin
                chk({"m_addr ", s}, m_addr[k], a & ~32'h3);
                chk({"m_we ", s}, 32'(m_we[k]), 32'(we));
                if (we != '0) chk({"m_wdata ", s}, m_wdata[k], wd);
            end
            own = ring_own[k][slot];
            chk({"i_rvalid ", s}, 32'(i_rvalid[k]), 32'(own == OWN_I));
            chk({"d_rvalid ", s}, 32'(d_rvalid[k]), 32'(own == OWN_D));
            chk({"g_rvalid ", s}, 32'(g_rvalid[k]), 32'(own == OWN_G));
            if (own != OWN_NONE) held[k][own] = ring_dat[k][slot];
            chk({"i_rdata ", s}, i_rdata[k], held[k][OWN_I]);
            chk({"d_rdata ", s}, d_rdata[k], held[k][OWN_D]);
            chk({"g_rdata ", s}, g_rdata[k], held[k][OWN_G]);
            chk({"g_locked ", s}, 32'(g_locked[k]), 32'(locked[k]));
            // advance the model across the coming clock edge
            infl = (n_fly[k] != 0);
            if (own != OWN_NONE) begin
                ring_own[k][slot] = OWN_NONE;
                n_fly[k]--;
            end
            if (i_req && win != OWN_I) starve[k] = (starve[k] < SMAX) ? starve[k] + 1 : SMAX;
            else                       starve[k] = 0;
            if (locked[k]) begin
                if (!g_lock) begin
                    locked[k] = 1'b0;
                    starve[k] = 0;
                end
            end else if (g_lock && !infl) begin
                locked[k] = 1'b1;
            end
            if (win != OWN_NONE && we == '0) begin
                ring_own[k][3'(cyc + ((k == 0) ? 1 : 3))] = win;
                ring_dat[k][3'(cyc + ((k == 0) ? 1 : 3))] = mem[a[9:2]];
                n_fly[k]++;
            end
            if (k == 0) last_win = win;
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int first_i, n_dgnt, n_dr, n_gl, n_idgnt;
        for (int w = 0; w < 256; w++) mem[w] = $urandom;
        for (int k = 0; k < 2; k++) for (int s = 0; s < 4; s++) rd_pipe[k][s] = '0;
        cyc = 0;
        reset = 1'b0;
        i_req = 0; d_req = 0; g_req = 0; g_lock = 0;
        i_addr = '0; d_addr = '0; g_addr = '0;
        d_we = '0; g_we = '0; d_wdata = '0; g_wdata = '0;
        model_clear();
        @(negedge clk);
        do_reset();

        // reset in the middle of a fetch: no response may follow
        i_req = 1; i_addr = 32'h10;
        step();
        do_reset();
        i_req = 0;
        repeat (4) step();

        // contention: D first, I next cycle
        i_req = 1; i_addr = 32'h40; d_req = 1; d_addr = 32'h104; d_we = '0;
        step();
        chk("contend d_first", 32'(obs_d_gnt), 32'd1);
        d_req = 0;
        step();
        chk("contend i_second", 32'(obs_i_gnt), 32'd1);
        i_req = 0;
        repeat (4) step();

        // starvation: D streams reads, I forced through on its 9th waiting cycle
        i_req = 1; i_addr = 32'h80; d_req = 1; d_addr = 32'h108;
        first_i = 0; n_dgnt = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (obs_d_gnt) n_dgnt++;
            if (obs_i_gnt && first_i == 0) begin
                first_i = n;
                i_req = 0;
            end
        end
        d_req = 0;
        chk("starve first_i_gnt", 32'(first_i), 32'd9);
        chk("starve d_grants", 32'(n_dgnt), 32'd19);
        repeat (4) step();

        // byte store, then read it back
        d_req = 1; d_addr = 32'h202; d_we = 4'b0100; d_wdata = 32'h00AB_0000;
        step();
        chk("store m_addr", obs_m_addr, 32'h200);
        chk("store m_we", 32'(obs_m_we), 32'h4);
        d_req = 0; d_we = '0;
        repeat (4) step();
        d_req = 1; d_addr = 32'h200;
        step();
        d_req = 0;
        repeat (4) step();
        chk("store readback", 32'(d_rdata[0][23:16]), 32'hAB);

        // lock with a D read in flight
        d_req = 1; d_addr = 32'h300;
        step();
        g_lock = 1; i_req = 1; i_addr = 32'h44; d_addr = 32'h304;
        n_dr = 0; n_gl = 0; n_idgnt = 0;
        for (int n = 1; n <= 6; n++) begin
            step();
            if (obs_d_rvalid && n_dr == 0) n_dr = n;
            if (obs_g_locked && n_gl == 0) n_gl = n;
            if (obs_i_gnt || obs_d_gnt) n_idgnt++;
        end
        chk("lock after drain", 32'(n_gl > n_dr && n_dr != 0), 32'd1);
        g_req = 1; g_addr = 32'h0; g_we = '0;
        step();
        if (obs_i_gnt || obs_d_gnt) n_idgnt++;
        g_req = 0;
        for (int n = 0; n < 4; n++) begin
            step();
            if (obs_i_gnt || obs_d_gnt) n_idgnt++;
        end
        chk("lock no id grants", 32'(n_idgnt), 32'd0);
        chk("lock g read data", g_rdata[0], mem[0]);
        g_lock = 0;
        step();
        chk("unlock still blocked", 32'(obs_i_gnt | obs_d_gnt), 32'd0);
        step();
        chk("unlock d resumes", 32'(obs_d_gnt), 32'd1);
        d_req = 0;
        step();
        chk("unlock i resumes", 32'(obs_i_gnt), 32'd1);
        i_req = 0;
        repeat (4) step();

        // back-to-back reads from alternating owners
        for (int r = 0; r < 2; r++) begin
            i_req = 1; i_addr = 32'(32'h100 + r * 16);
            step();
            i_req = 0; d_req = 1; d_addr = 32'(32'h180 + r * 16);
            step();
            d_req = 0; g_req = 1; g_addr = 32'(32'h1C0 + r * 16);
            step();
            g_req = 0;
        end
        repeat (5) step();

        // random traffic, requesters hold their command until granted
        for (int n = 0; n < 400; n++) begin
            if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req = 1; i_addr = 32'($urandom_range(0, 1023));
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1; d_addr = 32'($urandom_range(0, 1023));
                d_we = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
                d_wdata = $urandom;
            end
            if (!g_req && $urandom_range(0, 5) == 0) begin
                g_req = 1; g_addr = 32'($urandom_range(0, 1023));
                g_we = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
                g_wdata = $urandom;
            end
            step();
            case (last_win)
                OWN_I: i_req = 0;
                OWN_D: d_req = 0;
                OWN_G: g_req = 0;
                default: ;
            endcase
        end
        i_req = 0; d_req = 0; g_req = 0;
        repeat (5) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
